// File: rtl/polyphase_resampler_if.sv
// -----------------------------------------------------------------------------
// polyphase_resampler_if
// Groups the three handshake buses of the polyphase resampler:
//   in_*       : AXI-Stream sample input (tdata/tvalid/tready/tlast)
//   out_*      : AXI-Stream sample output (tdata/tvalid/tready/tlast)
//   coef_wr_*  : coefficient RAM write port (valid/ready/addr/data)
// modport slave  : the resampler's view (consumes in_*, coef_wr_*, drives out_*)
// modport master : the environment's view (the opposite directions)
// -----------------------------------------------------------------------------
interface polyphase_resampler_if #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int COEF_WIDTH     = 16,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH     = 5
);
  logic signed [DATA_IN_WIDTH-1:0]  in_tdata;
  logic                             in_tvalid;
  logic                             in_tready;
  logic                             in_tlast;

  logic signed [DATA_OUT_WIDTH-1:0] out_tdata;
  logic                             out_tvalid;
  logic                             out_tready;
  logic                             out_tlast;

  logic                             coef_wr_valid;
  logic                             coef_wr_ready;
  logic [ADDR_WIDTH-1:0]            coef_wr_addr;
  logic signed [COEF_WIDTH-1:0]     coef_wr_data;

  modport master (
    output in_tdata, in_tvalid, in_tlast,
    input  in_tready,
    input  out_tdata, out_tvalid, out_tlast,
    output out_tready,
    output coef_wr_valid, coef_wr_addr, coef_wr_data,
    input  coef_wr_ready
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast,
    output in_tready,
    output out_tdata, out_tvalid, out_tlast,
    input  out_tready,
    input  coef_wr_valid, coef_wr_addr, coef_wr_data,
    output coef_wr_ready
  );
endinterface

// File: rtl/polyphase_resampler.sv
// -----------------------------------------------------------------------------
// polyphase_resampler
// Single-clock polyphase FIR resampler built around one time-multiplexed MAC.
// MODE=1 interpolates by RATE (RATE outputs per input, one polyphase branch
// each); MODE=0 decimates by RATE (one full N-tap output per RATE inputs, or
// immediately on in_tlast). Results are shifted right by OUTPUT_SHIFT and
// saturated to DATA_OUT_WIDTH.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus          : polyphase_resampler_if.slave (input stream, output stream,
//                  coefficient write port); all readies high only in IDLE
//   sat_flag     : sticky, set when any output clips
//   busy         : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module polyphase_resampler #(
  parameter int MODE           = 1,
  parameter int RATE           = 4,
  parameter int TAPS_PER_PHASE = 8,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int COEF_WIDTH     = 16,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int OUTPUT_SHIFT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  polyphase_resampler_if.slave bus,
  output logic                 sat_flag,
  output logic                 busy
);
  localparam int N        = RATE * TAPS_PER_PHASE;
  localparam int ADDR_W   = $clog2(N);
  localparam int MAC_LEN  = (MODE == 1) ? TAPS_PER_PHASE : N;
  localparam int DL_LEN   = MAC_LEN;
  localparam int DL_IDX_W = (DL_LEN > 1) ? $clog2(DL_LEN) : 1;
  localparam int CNT_W    = $clog2(MAC_LEN + 2);
  localparam int PH_W     = $clog2(RATE);
  localparam int PROD_W   = DATA_IN_WIDTH + COEF_WIDTH;
  localparam int ACC_W    = PROD_W + ADDR_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [PH_W-1:0]                  phase_q, phase_d;
  logic [PH_W-1:0]                  in_count_q, in_count_d;
  logic                             last_q, last_d;
  logic signed [DATA_IN_WIDTH-1:0]  x_q [DL_LEN];
  logic signed [DATA_IN_WIDTH-1:0]  x_d [DL_LEN];
  logic signed [DATA_IN_WIDTH-1:0]  x_rd_q, x_rd_d;
  logic signed [PROD_W-1:0]         product_q, product_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic signed [DATA_OUT_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic                             out_tvalid_q, out_tvalid_d;
  logic                             out_tlast_q, out_tlast_d;
  logic                             sat_q, sat_d;

  logic signed [COEF_WIDTH-1:0]     coef_ram [N];
  logic signed [COEF_WIDTH-1:0]     coef_rd_q;
  logic [ADDR_W-1:0]                rd_addr;
  logic                             coef_we;

  logic signed [ACC_W-1:0]          acc_final;
  logic signed [ACC_W-1:0]          shifted;
  logic                             clip_hi, clip_lo;

  // The final product is folded in combinationally on the cycle the FSM
  // leaves MAC, which saves one cycle of latency versus accumulating first.
  assign acc_final = acc_q + ACC_W'(product_q);
  assign shifted   = acc_final >>> OUTPUT_SHIFT;
  assign clip_hi   = shifted > SAT_MAX;
  assign clip_lo   = shifted < SAT_MIN;

  assign coef_we           = (state_q == S_IDLE) && bus.coef_wr_valid;
  assign bus.in_tready     = (state_q == S_IDLE);
  assign bus.coef_wr_ready = (state_q == S_IDLE);
  assign bus.out_tdata     = out_tdata_q;
  assign bus.out_tvalid    = out_tvalid_q;
  assign bus.out_tlast     = out_tlast_q;
  assign sat_flag          = sat_q;
  assign busy              = (state_q != S_IDLE);

  // Coefficient RAM with registered read; not touched by reset.
  always_ff @(posedge clock) begin
    if (coef_we) begin
      coef_ram[bus.coef_wr_addr] <= bus.coef_wr_data;
    end
    coef_rd_q <= coef_ram[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    in_count_d   = in_count_q;
    last_d       = last_q;
    x_d          = x_q;
    x_rd_d       = x_rd_q;
    acc_d        = acc_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    sat_d        = sat_q;
    rd_addr      = '0;
    product_d    = PROD_W'(coef_rd_q) * PROD_W'(x_rd_q);

    // Tap fetch: cycle cnt issues RAM read and sample pick for tap cnt;
    // the product for tap cnt lands in product_q two cycles later.
    if (state_q == S_MAC && cnt_q < CNT_W'(MAC_LEN)) begin
      x_rd_d = x_q[DL_IDX_W'(cnt_q)];
      if (MODE == 1) begin
        rd_addr = ADDR_W'(int'(cnt_q) * RATE + int'(phase_q));
      end else begin
        rd_addr = ADDR_W'(cnt_q);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_tvalid) begin
          for (int i = DL_LEN - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0] = bus.in_tdata;
          last_d = bus.in_tlast;
          if (MODE == 1 || in_count_q == PH_W'(RATE - 1) || bus.in_tlast) begin
            state_d = S_MAC;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            in_count_d = in_count_q + PH_W'(1);
          end
        end
      end

      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(2)) begin
          acc_d = acc_final;
        end
        if (cnt_q == CNT_W'(MAC_LEN + 1)) begin
          state_d      = S_OUT;
          out_tvalid_d = 1'b1;
          out_tlast_d  = last_q && (MODE == 0 || phase_q == PH_W'(RATE - 1));
          if (clip_hi) begin
            out_tdata_d = DATA_OUT_WIDTH'(SAT_MAX);
            sat_d       = 1'b1;
          end else if (clip_lo) begin
            out_tdata_d = DATA_OUT_WIDTH'(SAT_MIN);
            sat_d       = 1'b1;
          end else begin
            out_tdata_d = DATA_OUT_WIDTH'(shifted);
          end
        end
      end

      S_OUT: begin
        if (bus.out_tready) begin
          out_tvalid_d = 1'b0;
          out_tlast_d  = 1'b0;
          if (MODE == 1 && phase_q != PH_W'(RATE - 1)) begin
            phase_d = phase_q + PH_W'(1);
            state_d = S_MAC;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            phase_d    = '0;
            in_count_d = '0;
            state_d    = S_IDLE;
            // End of frame: the next frame must start with zero history.
            if (out_tlast_q) begin
              x_d    = '{default: '0};
              last_d = 1'b0;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      in_count_q   <= '0;
      last_q       <= 1'b0;
      x_q          <= '{default: '0};
      x_rd_q       <= '0;
      product_q    <= '0;
      acc_q        <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      in_count_q   <= in_count_d;
      last_q       <= last_d;
      x_q          <= x_d;
      x_rd_q       <= x_rd_d;
      product_q    <= product_d;
      acc_q        <= acc_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      sat_q        <= sat_d;
    end
  end
endmodule

// File: tb/tb_polyphase_resampler.sv
// -----------------------------------------------------------------------------
// tb_polyphase_resampler
// Two resampler instances (dut0: interpolate x4, dut1: decimate x4), both with
// 2 taps per phase and no output shift. Stimulus drives samples/coefficients,
// a reference model pushes expected outputs into per-DUT queues, and a
// negedge monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_polyphase_resampler;
  localparam int RATE  = 4;
  localparam int TPP   = 2;
  localparam int N     = RATE * TPP;
  localparam int AW    = 3;
  localparam int SHIFT = 0;

  typedef struct {
    logic signed [15:0] data;
    logic               last;
    logic               sat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic               in_valid   [2];
  logic               in_last    [2];
  logic signed [15:0] in_data    [2];
  logic               coef_valid [2];
  logic [AW-1:0]      coef_addr  [2];
  logic signed [15:0] coef_data  [2];
  logic               out_ready  [2];
  logic               bp_low     [2];
  logic               in_ready   [2];
  logic               coef_ready [2];
  logic               out_valid  [2];
  logic               out_last   [2];
  logic signed [15:0] out_data   [2];
  logic [1:0]         sat_v, busy_v;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t   q0[$], q1[$];
  longint h    [2][N];
  longint hist [2][N];
  int     grp  [2];
  logic   sat_m[2];

  polyphase_resampler_if #(.DATA_IN_WIDTH(16), .COEF_WIDTH(16), .DATA_OUT_WIDTH(16), .ADDR_WIDTH(AW)) bus0 ();
  polyphase_resampler_if #(.DATA_IN_WIDTH(16), .COEF_WIDTH(16), .DATA_OUT_WIDTH(16), .ADDR_WIDTH(AW)) bus1 ();

  polyphase_resampler #(.MODE(1), .RATE(RATE), .TAPS_PER_PHASE(TPP), .DATA_IN_WIDTH(16),
    .COEF_WIDTH(16), .DATA_OUT_WIDTH(16), .OUTPUT_SHIFT(SHIFT)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .sat_flag(sat_v[0]), .busy(busy_v[0]));

  polyphase_resampler #(.MODE(0), .RATE(RATE), .TAPS_PER_PHASE(TPP), .DATA_IN_WIDTH(16),
    .COEF_WIDTH(16), .DATA_OUT_WIDTH(16), .OUTPUT_SHIFT(SHIFT)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .sat_flag(sat_v[1]), .busy(busy_v[1]));

  assign bus0.in_tdata      = in_data[0];
  assign bus0.in_tvalid     = in_valid[0];
  assign bus0.in_tlast      = in_last[0];
  assign bus0.coef_wr_valid = coef_valid[0];
  assign bus0.coef_wr_addr  = coef_addr[0];
  assign bus0.coef_wr_data  = coef_data[0];
  assign bus0.out_tready    = out_ready[0];
  assign in_ready[0]        = bus0.in_tready;
  assign coef_ready[0]      = bus0.coef_wr_ready;
  assign out_valid[0]       = bus0.out_tvalid;
  assign out_last[0]        = bus0.out_tlast;
  assign out_data[0]        = bus0.out_tdata;

  assign bus1.in_tdata      = in_data[1];
  assign bus1.in_tvalid     = in_valid[1];
  assign bus1.in_tlast      = in_last[1];
  assign bus1.coef_wr_valid = coef_valid[1];
  assign bus1.coef_wr_addr  = coef_addr[1];
  assign bus1.coef_wr_data  = coef_data[1];
  assign bus1.out_tready    = out_ready[1];
  assign in_ready[1]        = bus1.in_tready;
  assign coef_ready[1]      = bus1.coef_wr_ready;
  assign out_valid[1]       = bus1.out_tvalid;
  assign out_last[1]        = bus1.out_tlast;
  assign out_data[1]        = bus1.out_tdata;

  task automatic check(input string name, input int d, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_exp(input int d, input longint y, input logic last);
    longint r;
    exp_t   e;
    r = y >>> SHIFT;
    if (r > 32767) begin
      r = 32767;
      sat_m[d] = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat_m[d] = 1'b1;
    end
    e.data = 16'(r);
    e.last = last;
    e.sat  = sat_m[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void model_accept(input int d, input longint x, input logic last);
    longint y;
    for (int k = N - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
    hist[d][0] = x;
    if (d == 0) begin
      for (int p = 0; p < RATE; p++) begin
        y = 0;
        for (int j = 0; j < TPP; j++) y += h[0][j*RATE+p] * hist[0][j];
        push_exp(0, y, last && (p == RATE - 1));
      end
    end else begin
      grp[1]++;
      if (grp[1] == RATE || last) begin
        y = 0;
        for (int k = 0; k < N; k++) y += h[1][k] * hist[1][k];
        push_exp(1, y, last);
        grp[1] = 0;
      end
    end
    if (last) begin
      for (int k = 0; k < N; k++) hist[d][k] = 0;
      grp[d] = 0;
    end
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) hist[d][k] = 0;
      grp[d]   = 0;
      sat_m[d] = 1'b0;
    end
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input int d, input int x, input logic last,
                      input logic wc, input int caddr, input int cval);
    int t = 0;
    in_data[d]  = 16'(x);
    in_last[d]  = last;
    in_valid[d] = 1'b1;
    if (wc) begin
      coef_addr[d]  = AW'(caddr);
      coef_data[d]  = 16'(cval);
      coef_valid[d] = 1'b1;
    end
    @(negedge clock);
    while (!in_ready[d] && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready[d]) begin
      check("accept_timeout", d, 0, 1);
    end else begin
      @(posedge clock);
      if (wc) h[d][caddr] = longint'(signed'(16'(cval)));
      model_accept(d, longint'(signed'(16'(x))), last);
    end
    #1;
    in_valid[d]   = 1'b0;
    in_last[d]    = 1'b0;
    coef_valid[d] = 1'b0;
  endtask

  task automatic write_coef(input int d, input int addr, input int val);
    int t = 0;
    coef_addr[d]  = AW'(addr);
    coef_data[d]  = 16'(val);
    coef_valid[d] = 1'b1;
    @(negedge clock);
    while (!coef_ready[d] && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (!coef_ready[d]) begin
      check("coef_timeout", d, 0, 1);
    end else begin
      @(posedge clock);
      h[d][addr] = longint'(signed'(16'(val)));
    end
    #1;
    coef_valid[d] = 1'b0;
  endtask

  task automatic check_latency(input int d, input int expv);
    int cyc = 0;
    while (!out_valid[d] && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("latency", d, cyc, expv);
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    while ((qsize(d) != 0 || busy_v[d]) && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("drain_timeout", d, t < 3000, 1);
  endtask

  task automatic check_reset(input int d);
    check("rst_out_tvalid", d, out_valid[d], 0);
    check("rst_out_tlast", d, out_last[d], 0);
    check("rst_out_tdata", d, out_data[d], 0);
    check("rst_sat_flag", d, sat_v[d], 0);
    check("rst_busy", d, busy_v[d], 0);
    check("rst_in_tready", d, in_ready[d], 1);
    check("rst_coef_ready", d, coef_ready[d], 1);
  endtask

  task automatic random_run(input int d, input int count);
    int x, r;
    logic last, wc;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 3);
      x = (r == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
      last = ($urandom_range(0, 7) == 0);
      wc   = ($urandom_range(0, 4) == 0);
      send(d, x, last, wc, int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 64)) - 32);
    end
  endtask

  // ---------------- back-pressure ----------------
  always @(posedge clock) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = bp_low[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic               hold_v [2];
  logic signed [15:0] hold_d [2];

  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        hold_v[d] = 1'b0;
      end else begin
        if (hold_v[d]) begin
          check("stall_valid", d, out_valid[d], 1);
          check("stall_data", d, out_data[d], hold_d[d]);
        end
        if (out_valid[d]) begin
          check("in_tready_busy", d, in_ready[d], 0);
          check("coef_ready_busy", d, coef_ready[d], 0);
          if (out_ready[d]) begin
            if (qsize(d) == 0) begin
              check("unexpected_output", d, out_data[d], 0);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              check("out_tdata", d, out_data[d], e.data);
              check("out_tlast", d, out_last[d], e.last);
              check("sat_flag", d, sat_v[d], e.sat);
            end
          end
        end
        hold_v[d] = out_valid[d] && !out_ready[d];
        hold_d[d] = out_data[d];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]   = 1'b0;
      in_last[d]    = 1'b0;
      in_data[d]    = '0;
      coef_valid[d] = 1'b0;
      coef_addr[d]  = '0;
      coef_data[d]  = '0;
      out_ready[d]  = 1'b0;
      bp_low[d]     = 1'b0;
      hold_v[d]     = 1'b0;
      hold_d[d]     = '0;
      for (int k = 0; k < N; k++) h[d][k] = 0;
    end
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset(0);
    check_reset(1);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) write_coef(d, k, k + 1);

    // Interpolation impulse: 100 then 0 -> 100..800.
    send(0, 100, 1'b0, 1'b0, 0, 0);
    check_latency(0, TPP + 2);
    send(0, 0, 1'b0, 1'b0, 0, 0);
    wait_idle(0);

    // Long stall in OUT.
    bp_low[0] = 1'b1;
    send(0, 1234, 1'b0, 1'b0, 0, 0);
    check_latency(0, TPP + 2);
    repeat (20) @(posedge clock);
    #1;
    check("stall_busy", 0, busy_v[0], 1);
    check("stall_in_tready", 0, in_ready[0], 0);
    bp_low[0] = 1'b0;
    wait_idle(0);

    random_run(0, 40);
    wait_idle(0);

    // Reset mid-MAC, then replay the impulse scenario.
    for (int k = 0; k < N; k++) write_coef(0, k, k + 1);
    send(0, 777, 1'b0, 1'b0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_out_tvalid", 0, out_valid[0], 0);
    check("midrst_busy", 0, busy_v[0], 0);
    check("midrst_in_tready", 0, in_ready[0], 1);
    send(0, 100, 1'b0, 1'b0, 0, 0);
    check_latency(0, TPP + 2);
    send(0, 0, 1'b0, 1'b0, 0, 0);
    wait_idle(0);

    // Saturation and stickiness.
    for (int k = 0; k < N; k++) write_coef(0, k, 32767);
    send(0, 32767, 1'b0, 1'b0, 0, 0);
    wait_idle(0);
    check("sat_set", 0, sat_v[0], 1);
    for (int k = 0; k < N; k++) write_coef(0, k, 1);
    send(0, 5, 1'b0, 1'b0, 0, 0);
    send(0, 0, 1'b0, 1'b0, 0, 0);
    wait_idle(0);
    check("sat_sticky", 0, sat_v[0], 1);

    // Decimation: coefficients survived reset; ones -> 10, then 36.
    for (int i = 0; i < 3; i++) send(1, 1, 1'b0, 1'b0, 0, 0);
    send(1, 1, 1'b0, 1'b0, 0, 0);
    check_latency(1, N + 2);
    for (int i = 0; i < 4; i++) send(1, 1, 1'b0, 1'b0, 0, 0);
    wait_idle(1);
    // Frame end on the 2nd input of a group, then impulse in a fresh frame.
    send(1, 5, 1'b0, 1'b0, 0, 0);
    send(1, 7, 1'b1, 1'b0, 0, 0);
    check_latency(1, N + 2);
    wait_idle(1);
    send(1, 100, 1'b1, 1'b0, 0, 0);
    wait_idle(1);

    random_run(1, 40);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/polyphase_resampler.md
Name: polyphase_resampler

Overview:
- Single-clock polyphase FIR resampler: integer-factor interpolation or decimation, selected by parameter.
- Uses one time-multiplexed multiplier-accumulator (MAC), a sample delay line, and a writable coefficient RAM.
- Sits between the DVB symbol mapper and the DAC/pulse-shaping path in place of the per-phase parallel FIR array.
- Adds a decimation mode, frame-aware flushing, output saturation, and single-clock AXI-Stream handshakes throughout.

Parameters:
- MODE, 1, 0 = decimate, 1 = interpolate.
- RATE, 4, resampling factor, ≥2.
- TAPS_PER_PHASE, 8, taps per polyphase branch; total taps N = RATE*TAPS_PER_PHASE.
- DATA_IN_WIDTH, 16, signed input sample width.
- COEF_WIDTH, 16, signed coefficient width.
- DATA_OUT_WIDTH, 16, signed output width.
- OUTPUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clock  in  1  sole clock for all logic.
- reset  in  1  synchronous, active-high.
- in_tdata  in  DATA_IN_WIDTH  signed input sample.
- in_tvalid  in  1  input valid.
- in_tready  out  1  high only in IDLE.
- in_tlast  in  1  last sample of frame.
- out_tdata  out  DATA_OUT_WIDTH  signed output sample.
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  last output of frame.
- coef_wr_valid  in  1  coefficient write request.
- coef_wr_ready  out  1  high only in IDLE.
- coef_wr_addr  in  clog2(N)  tap index k.
- coef_wr_data  in  COEF_WIDTH  signed h[k].
- sat_flag  out  1  sticky; set when any output saturates.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values:
  - out_tvalid=0, out_tlast=0, out_tdata=0, sat_flag=0, busy=0.
  - in_tready=1 and coef_wr_ready=1 from the first cycle after reset.
  - Delay line cleared to 0; phase and input counters cleared to 0.
  - Coefficient RAM is NOT cleared by reset.
- Coefficient writes:
  - Accepted when coef_wr_valid & coef_wr_ready.
  - If a write and an input accept occur in the same IDLE cycle, both happen; the new coefficient takes effect from the MAC triggered by that input.
- Delay line: x[0] is the newest sample. On an input accept, all entries shift by one and x[0] takes in_tdata.
- State machine has three states: IDLE, MAC, OUT.
  - IDLE -> MAC on an input accept when a computation is due:
    - MODE=1: every accept.
    - MODE=0: when in_count==RATE-1, or in_tlast=1.
    - Otherwise (MODE=0 only): stay in IDLE and increment in_count.
  - MAC: one product per cycle, with a registered product stage.
    - MODE=1, phase p: acc = Σ_{j=0..TAPS_PER_PHASE-1} h[j*RATE+p]·x[j].
    - MODE=0: acc = Σ_{k=0..N-1} h[k]·x[k].
    - Leaves to OUT after the last product is accumulated.
  - OUT: out_tvalid=1, with out_tdata held stable until out_tready. On the handshake:
    - MODE=1 and p<RATE-1: p++, go to MAC.
    - Otherwise: p=0, in_count=0, go to IDLE.
- Latency: out_tvalid rises exactly MAC_LEN+2 cycles after the triggering input accept, or after the previous output handshake in MODE=1. MAC_LEN is TAPS_PER_PHASE (MODE=1) or N (MODE=0).
- Arithmetic:
  - Accumulator width is DATA_IN_WIDTH+COEF_WIDTH+clog2(N), full precision, no overflow possible.
  - result = acc >>> OUTPUT_SHIFT (floor), then saturate to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
  - A clipped result sets sat_flag until reset.
- Frame end (in_tlast accepted): the latched flag applies to the outputs that input triggers.
  - MODE=1: out_tlast=1 on the phase RATE-1 output only.
  - MODE=0: forces an immediate output regardless of in_count; that output carries out_tlast=1.
  - After the out_tlast handshake: delay line cleared to 0, counters cleared, return to IDLE. The next frame starts with zero history.
- Back-pressure: out_tready=0 stalls in OUT indefinitely. Nothing else changes state, and no input or coefficient write is accepted.
- Reset mid-operation: aborts any MAC/OUT immediately, with no partial output. All reset values apply on the next cycle.

Test Plan:
- MODE=1, RATE=4, TAPS_PER_PHASE=2, OUTPUT_SHIFT=0, h[k]=k+1, inputs 100 then 0 -> outputs 100,200,300,400,500,600,700,800; out_tvalid first rises 4 cycles after the first accept.
- MODE=0, same coefficients, constant input 1 -> first output 10 after 4 inputs, then 36 for every following group of 4 inputs.
- out_tready held low 20 cycles in OUT -> out_tdata/out_tvalid stable; in_tready=0 and coef_wr_ready=0 throughout; no sample lost.
- Saturation: DATA_OUT_WIDTH=16, OUTPUT_SHIFT=0, input 32767, all h=32767 -> out_tdata=32767, sat_flag=1 and remains 1.
- Frame end:
  - MODE=0, in_tlast on the 2nd input of a group -> immediate output with out_tlast=1.
  - Next frame with impulse 100 -> first output 100·h[0] only, confirming no residual history.
- Reset asserted mid-MAC -> next cycle out_tvalid=0, busy=0, in_tready=1; a subsequent impulse reproduces the first scenario exactly.
